// File: rtl/highscore_table.sv
// highscore_table: descending top-N score table filled by a scan/shift insertion FSM, with a registered read port.
// Optional live comparator port pair is compiled in when HIGHSCORE_LIVE_CMP_EN is defined.
module highscore_table #(
  parameter  int SCORE_W = 8,
  parameter  int DEPTH   = 4,
  localparam int IDX_W   = $clog2(DEPTH+1),
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [SCORE_W-1:0] in_score,
  output logic               in_ready,
  output logic               done,
  output logic               placed,
  output logic [IDX_W-1:0]   rank,
  output logic               new_record,
  output logic [SCORE_W-1:0] best_score,
  output logic [IDX_W-1:0]   count,
`ifdef HIGHSCORE_LIVE_CMP_EN
  input  logic [SCORE_W-1:0] live_score,
  output logic               live_beat,
`endif
  input  logic [ADDR_W-1:0]  rd_idx,
  output logic [SCORE_W-1:0] rd_score,
  output logic               rd_valid
);

  typedef enum logic [2:0] {IDLE, SCAN, SHIFT, WRITE, DONE} state_t;

  localparam logic [IDX_W-1:0]  DEPTH_I = IDX_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_I  = IDX_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH-1);

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   scoreTab_q [DEPTH];
  logic [IDX_W-1:0]     count_q;
  logic [SCORE_W-1:0]   pend_q;
  logic [ADDR_W-1:0]    scanIdx_q, ins_q, j_q;
  logic                 placed_q;
  logic [IDX_W-1:0]     rank_q;
  logic [SCORE_W-1:0]   rdScore_q;
  logic                 rdValid_q;

  logic                 scanHit;
  logic [ADDR_W-1:0]    shiftStart, jDec;
  logic [SCORE_W-1:0]   rdMux;

  // A slot is taken at the first vacancy or the first strictly smaller entry, so ties rank below older scores.
  assign scanHit    = (IDX_W'(scanIdx_q) == count_q) || (pend_q > scoreTab_q[scanIdx_q]);
  assign shiftStart = (count_q >= LAST_I) ? LAST_A : count_q[ADDR_W-1:0];
  assign jDec       = j_q - ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    done       = 1'b0;
    new_record = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SCAN;
      end
      SCAN: begin
        if (scanHit)                  state_d = (shiftStart == scanIdx_q) ? WRITE : SHIFT;
        else if (scanIdx_q == LAST_A) state_d = DONE;
      end
      SHIFT: begin
        if (jDec == ins_q) state_d = WRITE;
      end
      WRITE: state_d = DONE;
      DONE: begin
        done       = 1'b1;
        new_record = placed_q && (rank_q == '0);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdMux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_idx == ADDR_W'(i)) rdMux = scoreTab_q[i];
  end

  // Each SHIFT cycle moves one entry down; the entry pushed past the bottom is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) scoreTab_q[i] <= '0;
      count_q   <= '0;
      pend_q    <= '0;
      scanIdx_q <= '0;
      ins_q     <= '0;
      j_q       <= '0;
      placed_q  <= 1'b0;
      rank_q    <= '0;
      rdScore_q <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdScore_q <= rdMux;
      rdValid_q <= (IDX_W'(rd_idx) < count_q);
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pend_q    <= in_score;
            scanIdx_q <= '0;
          end
        end
        SCAN: begin
          if (scanHit) begin
            ins_q <= scanIdx_q;
            j_q   <= shiftStart;
          end else if (scanIdx_q == LAST_A) begin
            placed_q <= 1'b0;
            rank_q   <= DEPTH_I;
          end else begin
            scanIdx_q <= scanIdx_q + ADDR_W'(1);
          end
        end
        SHIFT: begin
          scoreTab_q[j_q] <= scoreTab_q[jDec];
          j_q             <= jDec;
        end
        WRITE: begin
          scoreTab_q[ins_q] <= pend_q;
          count_q           <= (count_q == DEPTH_I) ? count_q : count_q + IDX_W'(1);
          placed_q          <= 1'b1;
          rank_q            <= IDX_W'(ins_q);
        end
        default: ;
      endcase
    end
  end

`ifdef HIGHSCORE_LIVE_CMP_EN
  logic liveBeat_q;

  always_ff @(posedge clk) begin
    if (reset) liveBeat_q <= 1'b0;
    else       liveBeat_q <= (live_score > scoreTab_q[0]) || ((count_q == '0) && (live_score != '0));
  end

  assign live_beat = liveBeat_q;
`endif

  assign placed     = placed_q;
  assign rank       = rank_q;
  assign best_score = scoreTab_q[0];
  assign count      = count_q;
  assign rd_score   = rdScore_q;
  assign rd_valid   = rdValid_q;

endmodule

// File: tb/tb_highscore_table.sv
// tb_highscore_table: directed-sequence bench with a sorted-table reference model and a result scoreboard queue.
// Live comparator checks are compiled in when HIGHSCORE_LIVE_CMP_EN is defined.
module tb_highscore_table;

  localparam int SCORE_W = 8;
  localparam int DEPTH   = 4;
  localparam int IDX_W   = $clog2(DEPTH+1);
  localparam int ADDR_W  = $clog2(DEPTH);

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [SCORE_W-1:0] in_score;
  logic               in_ready;
  logic               done;
  logic               placed;
  logic [IDX_W-1:0]   rank;
  logic               new_record;
  logic [SCORE_W-1:0] best_score;
  logic [IDX_W-1:0]   count;
  logic [ADDR_W-1:0]  rd_idx;
  logic [SCORE_W-1:0] rd_score;
  logic               rd_valid;
`ifdef HIGHSCORE_LIVE_CMP_EN
  logic [SCORE_W-1:0] live_score;
  logic               live_beat;
`endif

  highscore_table #(.SCORE_W(SCORE_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_score   (in_score),
    .in_ready   (in_ready),
    .done       (done),
    .placed     (placed),
    .rank       (rank),
    .new_record (new_record),
    .best_score (best_score),
    .count      (count),
`ifdef HIGHSCORE_LIVE_CMP_EN
    .live_score (live_score),
    .live_beat  (live_beat),
`endif
    .rd_idx     (rd_idx),
    .rd_score   (rd_score),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    int placed;
    int rank;
    int newRec;
    int lat;
  } exp_t;

  exp_t sbQ[$];
  int   model[DEPTH];
  int   modelCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Submit one score; the reference table is updated and the expected outcome queued before driving.
  task automatic applyStimulus(input int score);
    exp_t e;
    int   pos;
    int   startCyc;
    int   k;
    pos = -1;
    for (int p = 0; p < DEPTH; p++)
      if (pos < 0 && (p == modelCount || score > model[p])) pos = p;
    if (pos < 0) begin
      e = '{0, DEPTH, 0, DEPTH + 1};
    end else begin
      e.lat = ((modelCount < DEPTH - 1) ? modelCount : DEPTH - 1) + 3;
      for (int q = DEPTH - 1; q > pos; q--) model[q] = model[q-1];
      model[pos] = score;
      if (modelCount < DEPTH) modelCount++;
      e.placed = 1;
      e.rank   = pos;
      e.newRec = (pos == 0) ? 1 : 0;
    end
    sbQ.push_back(e);

    @(negedge clk);
    in_valid = 1'b1;
    in_score = score[SCORE_W-1:0];
    @(negedge clk);
    in_valid = 1'b0;
    startCyc = cyc;
    checkOutput("busy_not_ready", in_ready, 0);
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    e = sbQ.pop_front();
    checkOutput("done_seen", done, 1);
    // done becomes visible one edge before the edge that samples it
    checkOutput("done_latency", cyc - startCyc + 1, e.lat);
    checkOutput("placed", placed, e.placed);
    checkOutput("rank", rank, e.rank);
    checkOutput("new_record", new_record, e.newRec);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("new_record_one_cycle", new_record, 0);
    checkOutput("rank_hold", rank, e.rank);
  endtask

  task automatic checkTable();
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = i[ADDR_W-1:0];
      @(negedge clk);
      checkOutput($sformatf("rd_score[%0d]", i), rd_score, (i < modelCount) ? model[i] : 0);
      checkOutput($sformatf("rd_valid[%0d]", i), rd_valid, (i < modelCount) ? 1 : 0);
    end
    checkOutput("best_score", best_score, (modelCount > 0) ? model[0] : 0);
    checkOutput("count", count, modelCount);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_score = '0;
    rd_idx   = '0;
`ifdef HIGHSCORE_LIVE_CMP_EN
    live_score = '0;
`endif
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_placed", placed, 0);
    checkOutput("reset_rank", rank, 0);
    checkOutput("reset_new_record", new_record, 0);
`ifdef HIGHSCORE_LIVE_CMP_EN
    checkOutput("reset_live_beat", live_beat, 0);
`endif
    checkTable();

    applyStimulus(50);
    applyStimulus(80);
    applyStimulus(30);
    applyStimulus(80);
    checkTable();

`ifdef HIGHSCORE_LIVE_CMP_EN
    live_score = 8'd79;
    @(negedge clk);
    checkOutput("live_beat_79", live_beat, 0);
    live_score = 8'd80;
    @(negedge clk);
    checkOutput("live_beat_80", live_beat, 0);
    live_score = 8'd81;
    @(negedge clk);
    checkOutput("live_beat_81", live_beat, 1);
    live_score = '0;
`endif

    applyStimulus(20);
    checkTable();
    applyStimulus(90);
    checkTable();

    // Abort an insertion while the table is shifting down.
    @(negedge clk);
    in_valid = 1'b1;
    in_score = 8'd95;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_count", count, 0);
    checkOutput("abort_best", best_score, 0);
    checkOutput("abort_done", done, 0);
    doneCount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("abort_no_done", doneCount, 0);
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    modelCount = 0;
    checkTable();

    applyStimulus(0);
    applyStimulus(0);
    applyStimulus(7);
    checkTable();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/highscore_table.md
# highscore_table

Sorted top-N high-score table for the game core. Accepts one final score per game over a valid/ready handshake and inserts it into a descending-order register table with a multi-cycle scan/shift state machine. Reports the achieved rank and a new-record pulse, and exposes the best score plus a registered read port for the display/VGA path. Replaces the single-register highest-score comparison with a parametrised N-entry table.

## Interface
- SCORE_W, 8, score width in bits (unsigned).
- DEPTH, 4, number of table entries (≥2).
- IDX_W, $clog2(DEPTH+1), width of count/rank fields (derived; do not override).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- in_valid  in  1  score submission valid.
- in_score  in  SCORE_W  final score of finished game.
- in_ready  out  1  high only in IDLE; transfer = in_valid & in_ready.
- done  out  1  one-cycle pulse when an insertion completes.
- placed  out  1  valid with done; score entered the table.
- rank  out  IDX_W  valid with done; 0-based position, DEPTH when not placed.
- new_record  out  1  one-cycle pulse coincident with done when rank==0.
- best_score  out  SCORE_W  entry 0; 0 when table empty.
- count  out  IDX_W  occupied entries, saturates at DEPTH.
- rd_idx  in  $clog2(DEPTH)  read address.
- rd_score  out  SCORE_W  registered entry at rd_idx, one-cycle latency.
- rd_valid  out  1  registered (rd_idx < count).

## Operation
- States: IDLE, SCAN, SHIFT, WRITE, DONE.
- IDLE: in_ready=1. On transfer, latch in_score into pend, scan_idx=0, go SCAN.
- SCAN: one entry per cycle at scan_idx. Hit when scan_idx==count (vacant slot) or pend > table[scan_idx] (strict; ties rank below the older entry). On hit: ins=scan_idx, go SHIFT. On miss with scan_idx==DEPTH-1: placed=0, rank=DEPTH, go DONE. Otherwise scan_idx+1.
- SHIFT: j starts at min(count, DEPTH-1). While j>ins: table[j]=table[j-1], j-1, one per cycle. When j==ins, go WRITE. Zero SHIFT cycles is valid (j==ins on entry → direct to WRITE next cycle); the bottom entry is discarded when full.
- WRITE: table[ins]=pend; count=min(count+1, DEPTH); placed=1, rank=ins; go DONE.
- DONE: done=1 (and new_record if placed & rank==0) for exactly one cycle, go IDLE.
- placed/rank hold until the next DONE.
- Read port: rd_score <= table[rd_idx] every cycle regardless of state; mid-update reads return in-progress contents; consumers qualify with in_ready.
- Score 0 places whenever count<DEPTH.

## Timing
- Reset: state IDLE, table all 0, count=0, in_ready=1 the cycle after reset deasserts; done/new_record/placed=0, rank=0, rd_score=0, rd_valid=0.
- Reset asserted in any state aborts the operation; the pending score is dropped and the table is cleared.
- Transfer at edge T. Placed score: SCAN ins+1 cycles, SHIFT (min(count,DEPTH-1)−ins) cycles, WRITE 1, DONE 1; done high in cycle T+ins+min(count,DEPTH-1)−ins+3. Not placed: done at T+DEPTH+1.
- in_valid during non-IDLE states is ignored (no queuing); back-to-back accept is possible the cycle after DONE.
- best_score and count update at the WRITE edge; they are stable while done is high.

## Configuration
- HIGHSCORE_LIVE_CMP_EN defined: adds ports live_score (in, SCORE_W) and live_beat (out, 1, registered). live_beat = (live_score > best_score) | (count==0 & live_score!=0), updated every cycle, 0 after reset. This drives the in-game "new high score" indicator.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

## Test plan
- Reset, then read all idx → rd_valid=0, rd_score=0, best_score=0, count=0, in_ready=1.
- Submit 50, 80, 30, 80 (DEPTH=4) → ranks 0,0,2,1; new_record on first two only; table 80,80,50,30; count=4.
- Table full {80,80,50,30}, submit 20 → done at T+5, placed=0, rank=4; table unchanged.
- Table full, submit 90 → rank=0, new_record=1; table 90,80,80,50 (30 dropped); done at T+6.
- Assert reset during SHIFT of an insertion → next cycle IDLE, count=0, table zero, no done pulse.
- With HIGHSCORE_LIVE_CMP_EN, best=80, sweep live_score 79/80/81 → live_beat 0/0/1 one cycle later.
